// File: rtl/dmpx_regs.sv
// Write-side demultiplexer for the calculator's one-hot 4:1 mux: steers din into one
// of four holding registers, by one-hot select or by a round-robin pointer.
module dmpx_regs #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic [3:0]   s,
  input  logic         we,
  input  logic         auto,
  input  logic         clr,
  output logic [W-1:0] R0,
  output logic [W-1:0] R1,
  output logic [W-1:0] R2,
  output logic [W-1:0] R3,
  output logic [3:0]   valid,
  output logic         ack,
  output logic         err,
  output logic [1:0]   ptr
);

  logic [W-1:0] regs [4];
  logic         sel_ok;
  logic [1:0]   sel_idx;
  logic [1:0]   wr_idx;
  logic         wr_go;
  logic         bad_sel;

  // Only the four single-bit codes decode; anything else is an illegal select.
  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = 2'd0;
    case (s)
      4'b0001: begin sel_ok = 1'b1; sel_idx = 2'd0; end
      4'b0010: begin sel_ok = 1'b1; sel_idx = 2'd1; end
      4'b0100: begin sel_ok = 1'b1; sel_idx = 2'd2; end
      4'b1000: begin sel_ok = 1'b1; sel_idx = 2'd3; end
      default: begin sel_ok = 1'b0; sel_idx = 2'd0; end
    endcase
  end

  assign wr_idx  = auto ? ptr : sel_idx;
  assign wr_go   = we && (auto || sel_ok);
  assign bad_sel = we && !auto && !sel_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      valid <= 4'b0000;
      ack   <= 1'b0;
      err   <= 1'b0;
      ptr   <= 2'd0;
    end else if (clr) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      valid <= 4'b0000;
      ack   <= 1'b0;
      err   <= 1'b0;
      ptr   <= 2'd0;
    end else begin
      ack <= wr_go;
      if (wr_go) begin
        regs[wr_idx]  <= din;
        valid[wr_idx] <= 1'b1;
      end
      if (we && auto) ptr <= ptr + 2'd1;
      // err is sticky; legal writes afterwards still complete
      if (bad_sel) err <= 1'b1;
    end
  end

  assign R0 = regs[0];
  assign R1 = regs[1];
  assign R2 = regs[2];
  assign R3 = regs[3];

endmodule

// File: tb/tb_dmpx_regs.sv
// Self-checking bench for dmpx_regs: directed plan steps followed by random traffic,
// all compared against an array-based reference model.
module tb_dmpx_regs;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic [3:0]   s;
  logic         we, auto, clr;
  logic [W-1:0] R0, R1, R2, R3;
  logic [3:0]   valid;
  logic         ack, err;
  logic [1:0]   ptr;

  int tests  = 0;
  int failed = 0;

  // reference model state
  int m_r [4];
  int m_valid [4];
  int m_ack, m_err, m_ptr;

  dmpx_regs #(.W(W)) dut (
    .clk(clk), .rst(rst), .din(din), .s(s), .we(we), .auto(auto), .clr(clr),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .valid(valid), .ack(ack), .err(err), .ptr(ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_r[i] = 0; m_valid[i] = 0; end
    m_ack = 0; m_err = 0; m_ptr = 0;
  endtask

  task automatic model_edge(input int w, input int a, input int sel, input int d, input int c);
    int nbits, pos, dst;
    if (c != 0) begin
      model_reset();
      return;
    end
    m_ack = 0;
    if (w == 0) return;
    if (a != 0) begin
      dst = m_ptr;
      m_ptr = (m_ptr + 1) % 4;
    end else begin
      nbits = 0; pos = 0;
      for (int b = 0; b < 4; b++) if (((sel >> b) & 1) == 1) begin nbits++; pos = b; end
      if (nbits != 1) begin
        m_err = 1;
        return;
      end
      dst = pos;
    end
    m_r[dst] = d;
    m_valid[dst] = 1;
    m_ack = 1;
  endtask

  task automatic check_all(input string tag);
    int vexp;
    vexp = m_valid[0] + 2 * m_valid[1] + 4 * m_valid[2] + 8 * m_valid[3];
    chk({tag, ".R0"}, 32'(R0), 32'(m_r[0]));
    chk({tag, ".R1"}, 32'(R1), 32'(m_r[1]));
    chk({tag, ".R2"}, 32'(R2), 32'(m_r[2]));
    chk({tag, ".R3"}, 32'(R3), 32'(m_r[3]));
    chk({tag, ".valid"}, 32'(valid), 32'(vexp));
    chk({tag, ".ack"}, 32'(ack), 32'(m_ack));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
    chk({tag, ".ptr"}, 32'(ptr), 32'(m_ptr));
  endtask

  // Called just after an edge; drives inputs, waits one edge, updates model, checks.
  task automatic cyc(input string tag, input logic w, input logic a, input logic [3:0] sel,
                     input logic [W-1:0] d, input logic c);
    we = w; auto = a; s = sel; din = d; clr = c;
    @(posedge clk);
    model_edge(int'(w), int'(a), int'(sel), int'(d), int'(c));
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [3:0] rs;
    rst = 1'b1; din = '0; s = 4'b0000; we = 1'b0; auto = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // one-hot writes to each register
    cyc("oh0", 1'b1, 1'b0, 4'b0001, 16'h0001, 1'b0);
    cyc("oh1", 1'b1, 1'b0, 4'b0010, 16'h0002, 1'b0);
    cyc("oh2", 1'b1, 1'b0, 4'b0100, 16'h0003, 1'b0);
    cyc("oh3", 1'b1, 1'b0, 4'b1000, 16'h0004, 1'b0);
    chk("plan1.valid", 32'(valid), 32'hF);
    chk("plan1.R3", 32'(R3), 32'h0004);
    cyc("idle", 1'b0, 1'b0, 4'b0000, 16'h0000, 1'b0);

    // auto writes wrapping the pointer
    for (int i = 0; i < 5; i++) cyc("auto", 1'b1, 1'b1, 4'b0000, W'(16'hA000 + i), 1'b0);
    chk("plan2.R0", 32'(R0), 32'hA004);
    chk("plan2.ptr", 32'(ptr), 32'd1);

    // illegal select, sticky err, legal write still works, zero select
    cyc("bad0110", 1'b1, 1'b0, 4'b0110, 16'hFFFF, 1'b0);
    chk("plan3.err", 32'(err), 32'd1);
    cyc("legal_after_err", 1'b1, 1'b0, 4'b0001, 16'h1234, 1'b0);
    chk("plan3.R0", 32'(R0), 32'h1234);
    cyc("bad0000", 1'b1, 1'b0, 4'b0000, 16'h5555, 1'b0);

    // clr wins over simultaneous write
    cyc("clr_we", 1'b1, 1'b0, 4'b0001, 16'h7777, 1'b1);
    chk("plan4.valid", 32'(valid), 32'h0);

    // auto ignores an illegal s
    cyc("auto_s1111", 1'b1, 1'b1, 4'b1111, 16'hBEEF, 1'b0);
    chk("plan5.err", 32'(err), 32'd0);
    cyc("auto_s1111b", 1'b1, 1'b1, 4'b1111, 16'hCAFE, 1'b0);

    // async reset between edges
    cyc("pre_rst", 1'b1, 1'b0, 4'b0100, 16'h4242, 1'b0);
    we = 1'b1; auto = 1'b0; s = 4'b0010; din = 16'h9999;
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #2 rst = 1'b0;
    cyc("post_rst", 1'b1, 1'b0, 4'b1000, 16'h00FF, 1'b0);
    chk("plan6.valid", 32'(valid), 32'h8);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) != 0) rs = 4'(1 << $urandom_range(0, 3));
      else rs = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("rnd_rst");
        #2 rst = 1'b0;
      end else begin
        cyc("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0), rs,
            W'($urandom), 1'($urandom_range(0, 29) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dmpx_regs.md
# dmpx_regs

Write-side counterpart of the calculator's one-hot 4:1 16-bit multiplexer. Routes a 16-bit result (`din`) into one of four 16-bit holding registers, selected by a one-hot code (`s`) or by an internal round-robin pointer. The registers drive the multiplexer's four data inputs. The block also reports write acknowledge, per-register valid flags, and a sticky error for illegal select codes.

## Interface
Parameters:
- `W`, 16, data width of `din` and of each holding register.

Ports:
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `din`  in  W  data to store.
- `s`  in  4  one-hot destination select: bit0→`R0`, bit1→`R1`, bit2→`R2`, bit3→`R3`.
- `we`  in  1  write request, sampled each rising edge.
- `auto`  in  1  when 1 with `we`, the destination is `ptr` and `s` is ignored.
- `clr`  in  1  synchronous clear of registers, valid flags and error.
- `R0`,`R1`,`R2`,`R3`  out  W each  holding registers; feed the multiplexer inputs I0..I3.
- `valid`  out  4  bit n = `Rn` has been written since the last reset or clear.
- `ack`  out  1  one-cycle pulse, the cycle after an accepted write.
- `err`  out  1  sticky illegal-select flag.
- `ptr`  out  2  next round-robin destination index.

## Operation
- Reset (`rst`=1, asynchronous): `R0`..`R3`=0, `valid`=0000, `ack`=0, `err`=0, `ptr`=0. The block holds this state while `rst` is high.
- Each rising edge, evaluate in this priority order:
  1. `clr`=1: `R0`..`R3`←0, `valid`←0000, `err`←0, `ptr`←0, `ack`←0. Any simultaneous `we` is dropped.
  2. `we`=1, `auto`=1: `R[ptr]`←`din`, `valid[ptr]`←1, `ptr`←`ptr`+1 mod 4 (3 wraps to 0), `ack`←1. `s` is ignored, including illegal codes.
  3. `we`=1, `auto`=0, `s` one-hot: `R[idx(s)]`←`din`, `valid[idx(s)]`←1, `ack`←1. `ptr` is unchanged.
  4. `we`=1, `auto`=0, `s` not one-hot (0000 or two or more bits set): no register or valid bit changes, `err`←1, `ack`←0.
  5. Otherwise: hold all state, `ack`←0.
- `err` is sticky. Only `clr` or `rst` clears it. Later legal writes still complete while `err`=1.
- Rewriting a register overwrites it; its `valid` bit stays 1.
- Back-to-back writes on consecutive cycles are all accepted. There is no backpressure and no busy state.
- `din` is stored at full width W, with no sign handling or truncation.
- Outputs come directly from flops, with no combinational path from inputs to outputs.

## Timing
- Write latency: the new `Rn` value and `valid` bit are visible immediately after the capturing edge (same edge where `we` is sampled high).
- `ack` is high for exactly the one cycle following each accepted write. With continuous accepted writes, `ack` stays high continuously.
- `ptr` advances on the same edge as an auto write.
- `err` rises on the edge that samples the illegal request.
- Reset mid-operation: asserting `rst` between edges clears all outputs immediately. A write in progress that cycle is lost.
- The first edge after `rst` deasserts behaves as a normal cycle.

## Test plan
- Reset, then `we`=1, `auto`=0, `din`=0x0001/0x0002/0x0003/0x0004 with `s`=0001/0010/0100/1000 on four consecutive edges → `R0..R3`=1,2,3,4, `valid`=1111, `ack` high for 4 cycles.
- `we`=1, `auto`=1, `din`=0xA000..0xA004 over five edges from `ptr`=0 → `R0`=0xA004 (wrapped), `R1`=0xA001, `R2`=0xA002, `R3`=0xA003, `ptr`=1.
- `we`=1, `auto`=0, `s`=0110, `din`=0xFFFF → registers unchanged, `ack`=0, `err`=1. Then a legal write `s`=0001, `din`=0x1234 → `R0`=0x1234, `err` still 1. Then `s`=0000 with `we`=1 → no change.
- `clr`=1 and `we`=1 on the same edge with `s`=0001 → all registers 0, `valid`=0000, `err`=0, `ptr`=0, `ack`=0.
- `auto`=1 with `s`=1111 and `we`=1 → write goes to `R[ptr]`, `err` stays 0.
- Assert `rst` asynchronously mid-cycle after several writes → all outputs 0 before the next edge. Deassert, then one write `s`=1000, `din`=0x00FF → `R3`=0x00FF, `valid`=1000.
